bht_access_arbiter: RTL and testbench
=====================================

# bht_access_arbiter

Shared-access scheduler for the 2-bit saturating-counter branch history table. Two fetch-side requesters (thread 0, thread 1) issue prediction lookups and one resolve-side port posts outcome updates; the block owns the single-port table, serialises all accesses to one per cycle, buffers updates in a small FIFO and sequences table initialisation after reset or flush. It sits between the fetch stage and branch resolution logic.

## Interface
- PC_W, 8, branch PC width
- IDX_W, 4, table index width; table has 2^IDX_W entries indexed by pc[IDX_W-1:0]
- FIFO_DEPTH, 4, update FIFO entries (power of two, ≥2)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous re-initialisation request (pulse)
- lk_valid  in  2  lookup request per requester (bit i = thread i)
- lk_pc0, lk_pc1  in  PC_W  lookup PC per requester
- lk_ready  out  2  lookup grant; transfer when lk_valid[i] & lk_ready[i]
- resp_valid  out  2  prediction valid for requester i (registered)
- resp_taken  out  1  prediction = counter MSB
- upd_valid  in  1  resolved-branch update
- upd_pc  in  PC_W  resolved branch PC
- upd_taken  in  1  actual outcome
- upd_ready  out  1  FIFO can accept (count < FIFO_DEPTH and state RUN and !flush)
- init_done  out  1  high in RUN
- stall_count  out  16  cycles where any lk_valid bit was high but not granted, saturating at 0xFFFF

## Operation
- States: INIT, RUN. Reset → INIT, init_idx=0.
- INIT: writes 2'b01 (weakly not-taken) to entry init_idx each cycle; after entry 2^IDX_W−1 → RUN. Takes exactly 2^IDX_W cycles. lk_ready=0, upd_ready=0.
- flush in any state: FIFO emptied, init_idx=0, next state INIT; no grant or enqueue in the flush cycle. Flush during INIT restarts at index 0.
- RUN, per cycle exactly one of:
  - Drain: if FIFO count==FIFO_DEPTH, or count>0 and lk_valid==0 → head entry applied: taken increments unless 2'b11, not-taken decrements unless 2'b00; lk_ready=0.
  - Lookup: else if any lk_valid → one grant. Both valid: grant rr pointer's requester. Pointer is set to the non-granted requester after every grant (single-requester grants included).
  - Idle otherwise.
- Enqueue (upd_valid & upd_ready) is independent of the slot choice; enqueue and dequeue may occur in the same cycle (count unchanged). No enqueue when full, even if draining.
- Lookup reads table contents as of cycle start; pending FIFO updates to the same index are not forwarded. Drain write takes effect at cycle end.
- stall_count increments on cycles in RUN with (lk_valid & ~lk_ready) != 0; not counted in INIT or flush cycles. Cleared only by reset.

## Timing
- Reset values: lk_ready=0, resp_valid=2'b00, resp_taken=0, upd_ready=0, init_done=0, stall_count=0, rr=0 (thread 0 first), FIFO empty.
- lk_ready and upd_ready combinational from current state and inputs; resp_valid/resp_taken registered: response one cycle after grant, one-hot, held one cycle.
- A grant in the cycle before flush still responds in the flush cycle.
- Update-to-visibility: enqueued at cycle N, earliest table effect end of cycle N+1 (drain at N+1 if lookups idle).
- Worst lookup wait under both-valid contention: 1 cycle, plus FIFO_DEPTH-full drain cycles.
- Reset asserted mid-operation: all state discarded immediately, INIT restarts on release.

## Test plan
- Reset release, no stimulus → init_done rises after exactly 16 cycles; upd_ready high from cycle 16; all entries read 2'b01 (lookup any PC → resp_taken=0).
- Both threads continuously valid, FIFO empty → grants alternate 0,1,0,1; each resp_valid one cycle after grant; stall_count +1 per cycle.
- Enqueue 3 taken updates for pc=0x25 with lookups idle, then lookup thread 0 pc=0x15 → counter 11, resp_taken=1.
- Hold both lk_valid high, enqueue 4 updates → upd_ready=0 at count 4, next cycle drain (lk_ready=2'b00), upd_ready back high.
- Same cycle: enqueue + drain at count 2 → count stays 2; decrement at 2'b00 stays 2'b00 (4 not-taken updates on fresh entry).
- Flush at cycle 5 of RUN with FIFO count 3 → FIFO empty, 16 INIT cycles, lk_ready=0 throughout, stall_count unchanged during INIT.

Source files
------------

// File: rtl/bht_access_arbiter.sv
// Single-port 2-bit branch history table with a round-robin lookup arbiter,
// a buffered update FIFO and a post-reset/flush initialisation sequencer.
module bht_access_arbiter #(
    parameter int unsigned PC_W       = 8,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic [1:0]      lk_valid,
    input  logic [PC_W-1:0] lk_pc0,
    input  logic [PC_W-1:0] lk_pc1,
    output logic [1:0]      lk_ready,
    output logic [1:0]      resp_valid,
    output logic            resp_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            upd_ready,
    output logic            init_done,
    output logic [15:0]     stall_count
);
    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   init_idx;
    logic [1:0]         bht [ENTRIES];
    logic [IDX_W-1:0]   fifo_idx [FIFO_DEPTH];
    logic               fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               rr;
    logic               drain, enq, grant_sel, stall_hit;
    logic [1:0]         grant;
    logic [IDX_W-1:0]   lk_idx, head_idx;
    logic [1:0]         head_ctr, head_next;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{lk_pc0[PC_W-1:IDX_W], lk_pc1[PC_W-1:IDX_W], upd_pc[PC_W-1:IDX_W]};

    // Slot choice: forced drain when full or lookups idle, else one lookup grant.
    always_comb begin
        state_next = state;
        drain      = 1'b0;
        grant      = 2'b00;
        grant_sel  = 1'b0;
        upd_ready  = 1'b0;
        case (state)
            INIT: begin
                if (init_idx == IDX_W'(ENTRIES - 1)) state_next = RUN;
            end
            RUN: begin
                upd_ready = (count < CNT_W'(FIFO_DEPTH));
                if (count == CNT_W'(FIFO_DEPTH) || (count != '0 && lk_valid == 2'b00)) begin
                    drain = 1'b1;
                end else if (lk_valid != 2'b00) begin
                    grant_sel = (lk_valid == 2'b11) ? rr : lk_valid[1];
                    grant     = 2'b01 << grant_sel;
                end
            end
            default: state_next = INIT;
        endcase
        if (flush) begin
            state_next = INIT;
            drain      = 1'b0;
            grant      = 2'b00;
            upd_ready  = 1'b0;
        end
    end

    assign lk_ready  = grant;
    assign init_done = (state == RUN);
    assign enq       = upd_valid & upd_ready;
    assign lk_idx    = grant_sel ? lk_pc1[IDX_W-1:0] : lk_pc0[IDX_W-1:0];
    assign head_idx  = fifo_idx[rd_ptr];
    assign head_ctr  = bht[head_idx];
    assign stall_hit = (state == RUN) && !flush && ((lk_valid & ~grant) != 2'b00);

    always_comb begin
        head_next = head_ctr;
        if (fifo_taken[rd_ptr]) begin
            if (head_ctr != 2'b11) head_next = 2'(head_ctr + 2'd1);
        end else begin
            if (head_ctr != 2'b00) head_next = 2'(head_ctr - 2'd1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state    <= state_next;
            init_idx <= (flush || state == RUN) ? '0 : IDX_W'(init_idx + 1'b1);
        end
    end

    // Table contents are defined by the INIT sweep, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (state == INIT && !flush) bht[init_idx] <= 2'b01;
        else if (drain)              bht[head_idx] <= head_next;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_idx[wr_ptr]   <= upd_pc[IDX_W-1:0];
            fifo_taken[wr_ptr] <= upd_taken;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)   wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (drain) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            case ({enq, drain})
                2'b10:   count <= CNT_W'(count + 1'b1);
                2'b01:   count <= CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr          <= 1'b0;
            resp_valid  <= 2'b00;
            resp_taken  <= 1'b0;
            stall_count <= '0;
        end else begin
            if (grant != 2'b00) rr <= ~grant_sel;
            resp_valid <= grant;
            resp_taken <= (grant != 2'b00) ? bht[lk_idx][1] : 1'b0;
            if (stall_hit && stall_count != 16'hFFFF) stall_count <= 16'(stall_count + 1'b1);
        end
    end
endmodule

// File: tb/tb_bht_access_arbiter.sv
// Directed bench for bht_access_arbiter: a queue/array model checked every cycle
// plus literal expectations for the headline scenarios.
module tb_bht_access_arbiter;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset_n, flush, upd_valid, upd_taken;
    logic [1:0]  lk_valid;
    logic [7:0]  lk_pc0, lk_pc1, upd_pc;
    logic [1:0]  lk_ready, resp_valid;
    logic        resp_taken, upd_ready, init_done;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;

    bht_access_arbiter #(.PC_W(8), .IDX_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .lk_valid(lk_valid), .lk_pc0(lk_pc0), .lk_pc1(lk_pc1), .lk_ready(lk_ready),
        .resp_valid(resp_valid), .resp_taken(resp_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .init_done(init_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: counter values as integers, the FIFO as queues.
    int          tbl [ENTRIES];
    int          q_idx [$];
    bit          q_tk [$];
    bit          m_run, m_rr, m_resp_t;
    int          m_init, m_stall, sel, h;
    bit          t, e_drain, e_updr;
    logic [1:0]  m_resp_v, e_lkr;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_lk_ready", lk_ready, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_taken", resp_taken, 0);
            check("rst_upd_ready", upd_ready, 0);
            check("rst_init_done", init_done, 0);
            check("rst_stall", stall_count, 0);
            m_run = 0; m_init = 0; m_rr = 0; m_stall = 0; m_resp_v = 0; m_resp_t = 0;
            q_idx.delete(); q_tk.delete();
        end else begin
            e_lkr = 0; e_drain = 0; e_updr = 0; sel = 0;
            if (m_run && !flush) begin
                e_updr = (q_idx.size() < DEPTH);
                if (q_idx.size() == DEPTH || (q_idx.size() > 0 && lk_valid == 0)) e_drain = 1;
                else if (lk_valid != 0) begin
                    if (lk_valid == 2'b11) sel = int'(m_rr);
                    else sel = lk_valid[0] ? 0 : 1;
                    e_lkr = 2'(1 << sel);
                end
            end
            check("m_lk_ready", lk_ready, e_lkr);
            check("m_upd_ready", upd_ready, e_updr);
            check("m_init_done", init_done, m_run);
            check("m_resp_valid", resp_valid, m_resp_v);
            if (m_resp_v != 0) check("m_resp_taken", resp_taken, m_resp_t);
            check("m_stall", stall_count, m_stall);

            m_resp_v = e_lkr;
            if (e_lkr != 0) begin
                m_resp_t = tbl[sel ? lk_pc1[3:0] : lk_pc0[3:0]] >= 2;
                m_rr = (sel == 0);
            end
            if (m_run && !flush && (lk_valid & ~e_lkr) != 0 && m_stall < 65535) m_stall++;
            if (flush) begin
                q_idx.delete(); q_tk.delete();
                m_run = 0; m_init = 0;
            end else if (!m_run) begin
                tbl[m_init] = 1;
                m_init++;
                if (m_init == ENTRIES) begin m_run = 1; m_init = 0; end
            end else begin
                if (e_drain) begin
                    h = q_idx.pop_front();
                    t = q_tk.pop_front();
                    if (t) tbl[h] = (tbl[h] == 3) ? 3 : tbl[h] + 1;
                    else   tbl[h] = (tbl[h] == 0) ? 0 : tbl[h] - 1;
                end
                if (upd_valid && e_updr) begin
                    q_idx.push_back(int'(upd_pc[3:0]));
                    q_tk.push_back(upd_taken);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle_inputs();
        flush = 0; lk_valid = 0; lk_pc0 = 0; lk_pc1 = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!init_done && n < 40) begin n++; @(negedge clk); end
        check(name, n, 16);
        check({name, "_upd_ready"}, upd_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] saved;
        reset_n = 0;
        idle_inputs();
        step(3);
        reset_n = 1;
        wait_init("init_cycles");

        // Both threads contending: strict alternation starting with thread 0.
        lk_valid = 2'b11; lk_pc0 = 8'h10; lk_pc1 = 8'h21;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("alt_grant", lk_ready, (i % 2 == 0) ? 1 : 2);
            if (i > 0) check("alt_resp", resp_valid, (i % 2 == 1) ? 1 : 2);
            @(posedge clk); #1;
        end
        lk_valid = 0;
        @(negedge clk);
        check("alt_last_resp", resp_valid, 2);
        check("alt_resp_taken", resp_taken, 0);
        check("alt_stall", stall_count, 6);
        @(posedge clk); #1;

        // Three taken updates to index 5 saturate it at 2'b11.
        upd_valid = 1; upd_pc = 8'h25; upd_taken = 1;
        step(3);
        upd_valid = 0;
        step(3);
        lk_valid = 2'b01; lk_pc0 = 8'h15;
        step(1);
        lk_valid = 0;
        @(negedge clk);
        check("taken_resp_valid", resp_valid, 1);
        check("taken_resp_taken", resp_taken, 1);
        @(posedge clk); #1;

        // FIFO fills under lookup pressure, then a forced drain.
        lk_valid = 2'b11; upd_valid = 1; upd_pc = 8'h07; upd_taken = 0;
        step(4);
        @(negedge clk);
        check("full_upd_ready", upd_ready, 0);
        check("full_lk_ready", lk_ready, 0);
        @(posedge clk); #1;
        upd_valid = 0;
        @(negedge clk);
        check("after_drain_upd_ready", upd_ready, 1);
        check("after_drain_grant", lk_ready != 0, 1);
        @(posedge clk); #1;
        lk_valid = 0;
        step(4);

        // Enqueue+drain at count 2, and decrement saturation on index 9.
        lk_valid = 2'b01; lk_pc0 = 8'h40; upd_valid = 1; upd_pc = 8'h09; upd_taken = 0;
        step(2);
        lk_valid = 0;
        step(2);
        upd_valid = 0;
        step(3);
        upd_valid = 1; upd_taken = 1;
        step(1);
        upd_valid = 0;
        step(2);
        lk_valid = 2'b10; lk_pc1 = 8'h09;
        step(1);
        lk_valid = 0;
        @(negedge clk);
        check("sat_resp_valid", resp_valid, 2);
        check("sat_resp_taken", resp_taken, 0);
        @(posedge clk); #1;

        // Flush with three pending updates: FIFO discarded, full re-initialisation.
        lk_valid = 2'b11; lk_pc0 = 8'h0C; lk_pc1 = 8'h0C;
        upd_valid = 1; upd_pc = 8'h0C; upd_taken = 1;
        step(3);
        upd_valid = 0; flush = 1;
        @(negedge clk);
        saved = stall_count;
        check("flush_lk_ready", lk_ready, 0);
        check("flush_upd_ready", upd_ready, 0);
        @(posedge clk); #1;
        flush = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("reinit_lk_ready", lk_ready, 0);
            check("reinit_stall", stall_count, saved);
            check("reinit_init_done", init_done, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("reinit_done", init_done, 1);
        check("reinit_grant", lk_ready != 0, 1);
        @(posedge clk); #1;
        lk_valid = 0;
        step(1);
        lk_valid = 2'b01;
        step(1);
        lk_valid = 0;
        @(negedge clk);
        check("flush_discard_taken", resp_taken, 0);
        check("flush_discard_valid", resp_valid, 1);
        @(posedge clk); #1;

        // Reset mid-operation discards everything and re-runs INIT.
        lk_valid = 2'b11; upd_valid = 1; upd_pc = 8'h03; upd_taken = 1;
        step(2);
        reset_n = 0;
        @(negedge clk);
        check("midrst_stall", stall_count, 0);
        @(posedge clk); #1;
        idle_inputs();
        step(1);
        reset_n = 1;
        wait_init("reinit_cycles");
        lk_valid = 2'b01; lk_pc0 = 8'h03;
        step(1);
        lk_valid = 0;
        @(negedge clk);
        check("midrst_resp_taken", resp_taken, 0);
        @(posedge clk); #1;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
